pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline register for the RISC-V pipeline. It replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers with one block. It carries an opaque payload of configurable width and uses valid/ready flow control instead of a global busywait. It adds synchronous flush (bubble insertion) and an optional two-entry skid buffer that breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_slot.sv | 30 +++
 rtl/pipe_stage_reg.sv | 168 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline register (pipe_stage_reg)
// and the per-stage instantiations of the RISC-V pipeline.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

  localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE = {32'h0000_0000, RV_NOP};

endpackage

// File: rtl/pipe_skid_slot.sv
// Single storage slot (payload plus valid bit) with load and clear, used as the
// second entry of pipe_stage_reg when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_slot #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Slot storage; clear wins over load so a flush always empties the slot.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid <= 1'b0;
      data  <= BUBBLE_VAL;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else begin
      valid <= valid;
      data  <= data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush. Defining PIPE_STAGE_SKID_EN
// selects a two-entry skid buffer with registered in_ready; otherwise one entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_t       state_r;
  pipe_state_t       state_next_s;
  logic              out_valid_r;
  logic              in_ready_r;
  logic [DATA_W-1:0] main_data_r;
  logic              main_load_s;
  logic              main_shift_s;
  logic              main_clear_s;
  logic              skid_load_s;
  logic              skid_clear_s;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic              accept_s;
  logic              consume_s;

  assign accept_s  = in_valid && in_ready_r;
  assign consume_s = out_valid_r && out_ready;

  pipe_skid_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .clear     (skid_clear_s),
    .load      (skid_load_s),
    .load_data (in_data),
    .valid     (skid_valid_s),
    .data      (skid_data_s)
  );

  // Next-state and datapath steering for the EMPTY/ONE/TWO occupancy FSM.
  always_comb begin
    state_next_s = state_r;
    main_load_s  = 1'b0;
    main_shift_s = 1'b0;
    main_clear_s = 1'b0;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    if (flush) begin
      state_next_s = EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_next_s = ONE;
            main_load_s  = 1'b1;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && consume_s) begin
            main_load_s = 1'b1;
          end else if (accept_s) begin
            state_next_s = TWO;
            skid_load_s  = 1'b1;
          end else if (consume_s) begin
            state_next_s = EMPTY;
            main_clear_s = 1'b1;
          end else begin
            state_next_s = ONE;
          end
        end
        TWO: begin
          if (consume_s) begin
            state_next_s = ONE;
            main_shift_s = 1'b1;
            skid_clear_s = 1'b1;
          end else begin
            state_next_s = TWO;
          end
        end
        default: begin
          state_next_s = EMPTY;
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State, main entry and registered handshake outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      main_data_r <= BUBBLE_VAL;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != EMPTY);
      in_ready_r  <= (state_next_s != TWO);
      if (main_clear_s) begin
        main_data_r <= BUBBLE_VAL;
      end else if (main_load_s) begin
        main_data_r <= in_data;
      end else if (main_shift_s) begin
        main_data_r <= skid_data_s;
      end else begin
        main_data_r <= main_data_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data_r;
  assign occ       = skid_valid_s ? 2'd2 : (out_valid_r ? 2'd1 : 2'd0);

`else

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              accept_s;

  // Single entry: the stage can take a new item whenever the current one leaves.
  assign in_ready = !valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Single-entry register; an emptied stage shows the bubble payload.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      valid_r <= 1'b0;
      data_r  <= BUBBLE_VAL;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
      data_r  <= BUBBLE_VAL;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign occ       = {1'b0, valid_r};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a scoreboard queue of expected outputs;
// covers both the single-entry and the PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_reg;

  localparam logic [31:0] BUB = 32'h0000_0013;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] FULL_OCC = 2'd2;
`else
  localparam logic [1:0] FULL_OCC = 2'd1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(BUB)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every output transfer (decided at the next posedge) pops one expected item.
  always @(negedge clock) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sb_order: got %h expected %h", out_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    cyc(); cyc();
    // Reset, with a transfer offered that must be ignored
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, BUB);
    chk("rst_occ", {30'd0, occ}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    cyc();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_data", out_data, BUB);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Stream 1..8 with one-cycle latency and no gaps
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 32'(k); exp_q.push_back(32'(k));
      cyc();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", out_data, 32'(k));
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_data", out_data, BUB);

`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b1; in_data = 32'd1; exp_q.push_back(32'd1);
    cyc();
    out_ready = 1'b0; in_data = 32'd2; exp_q.push_back(32'd2);
    cyc();
    chk("skid_occ2", {30'd0, occ}, 32'd2);
    chk("skid_ready0", {31'd0, in_ready}, 32'd0);
    in_data = 32'd3; exp_q.push_back(32'd3);
    cyc();
    chk("skid_hold_data", out_data, 32'd1);
    chk("skid_hold_occ", {30'd0, occ}, 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("skid_shift_data", out_data, 32'd2);
    chk("skid_shift_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("skid_third", out_data, 32'd3);
    in_valid = 1'b0;
    cyc();
    chk("skid_empty_occ", {30'd0, occ}, 32'd0);
`else
    in_valid = 1'b1; in_data = 32'h0000_00AA; out_ready = 1'b0; exp_q.push_back(32'h0000_00AA);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'h0000_00AA);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_ready_comb", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_release_data", out_data, BUB);
`endif

    // Flush with the stage full and a new item 6 offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd4;
    cyc();
    in_data = 32'd5;
    cyc();
    chk("pre_flush_occ", {30'd0, occ}, {30'd0, FULL_OCC});
    flush = 1'b1; in_data = 32'd6;
    cyc();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_occ", {30'd0, occ}, 32'd0);
    chk("flush_data", out_data, BUB);
    flush = 1'b0; out_ready = 1'b1; in_data = 32'd8; exp_q.push_back(32'd8);
    cyc();
    chk("post_flush_data", out_data, 32'd8);
    in_valid = 1'b0;
    cyc();
    chk("post_flush_empty", {31'd0, out_valid}, 32'd0);

    // Reset during a stall with one item held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd7;
    cyc();
    in_valid = 1'b0;
    chk("stall1_occ", {30'd0, occ}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_stall_occ", {30'd0, occ}, 32'd0);
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'd9; exp_q.push_back(32'd9);
    cyc();
    chk("item9_valid", {31'd0, out_valid}, 32'd1);
    chk("item9_data", out_data, 32'd9);
    in_valid = 1'b0;
    cyc(); cyc();
    chk("final_empty", {31'd0, out_valid}, 32'd0);
    chk("sb_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
